// File: rtl/ptmch_pkg.sv
// Purpose : shared constants and types for the SPI-NAND command monitor.
// Latency : n/a (declarations only).
// Backpressure: n/a. Exports opcodes, FSM states, TRG_CMD encoding, counter width, helpers.
package ptmch_pkg;

  localparam int CNT_W  = 32;
  localparam int ADDR_W = 24;

  localparam logic [7:0] P_OP_PRGEXCT = 8'h10;
  localparam logic [7:0] P_OP_RDSTAT  = 8'h0F;
  localparam logic [7:0] P_OP_BLKERS  = 8'hD8;
  localparam logic [7:0] P_OP_PDREAD  = 8'h13;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  // Encoding doubles as the TRG_CMD output value.
  typedef enum logic [1:0] {
    CMD_PRGEXCT = 2'd0,
    CMD_RDSTAT  = 2'd1,
    CMD_BLKERS  = 2'd2,
    CMD_PDREAD  = 2'd3
  } cmd_e;

  typedef struct packed {
    logic       known;
    cmd_e       cmd;
    logic [4:0] addr_last;   // index of the final address bit (len - 1)
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [7:0] op);
    op_dec_t d;
    d.known     = 1'b1;
    d.cmd       = CMD_PRGEXCT;
    d.addr_last = 5'd23;
    case (op)
      P_OP_PRGEXCT: d.cmd = CMD_PRGEXCT;
      P_OP_RDSTAT: begin
        d.cmd       = CMD_RDSTAT;
        d.addr_last = 5'd7;
      end
      P_OP_BLKERS:  d.cmd = CMD_BLKERS;
      P_OP_PDREAD:  d.cmd = CMD_PDREAD;
      default:      d.known = 1'b0;
    endcase
    return d;
  endfunction

  // Saturating increment: all-ones stays all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

endpackage

// File: rtl/ptmch_cmd_mon_if.sv
// Purpose : raw flash SPI bus as seen by the monitor (all three lines asynchronous to CLK100M).
// Latency : n/a (wires only).
// Backpressure: none; the monitor only observes. master drives the bus, slave observes it.
interface ptmch_cmd_mon_if;
  logic SPI_CS_N;
  logic SPI_SCK;
  logic SPI_MOSI;

  modport master (output SPI_CS_N, output SPI_SCK, output SPI_MOSI);
  modport slave  (input  SPI_CS_N, input  SPI_SCK, input  SPI_MOSI);
endinterface

// File: rtl/ptmch_spi_sync.sv
// Purpose : 2-flop synchronizers for CS_N/SCK/MOSI plus SCK-rise and CS_N rise/fall detect.
// Latency : pin to cs_n_s/mosi_s 2 cycles; edge strobes valid in the cycle after that.
// Backpressure: none. Ports: CLK100M, RESET_N, spi (slave), cs_n_s, cs_fall, cs_rise, sck_rise, mosi_s, sync_vld.
module ptmch_spi_sync (
  input  logic                  CLK100M,
  input  logic                  RESET_N,
  ptmch_cmd_mon_if.slave        spi,
  output logic                  cs_n_s,
  output logic                  cs_fall,
  output logic                  cs_rise,
  output logic                  sck_rise,
  output logic                  mosi_s,
  output logic                  sync_vld
);

  logic       cs_meta_q,   cs_meta_d;
  logic       cs_sync_q,   cs_sync_d;
  logic       cs_dly_q,    cs_dly_d;
  logic       sck_meta_q,  sck_meta_d;
  logic       sck_sync_q,  sck_sync_d;
  logic       sck_dly_q,   sck_dly_d;
  logic       mosi_meta_q, mosi_meta_d;
  logic       mosi_sync_q, mosi_sync_d;
  logic [2:0] prime_q,     prime_d;

  always_comb begin
    cs_meta_d   = spi.SPI_CS_N;
    cs_sync_d   = cs_meta_q;
    cs_dly_d    = cs_sync_q;
    sck_meta_d  = spi.SPI_SCK;
    sck_sync_d  = sck_meta_q;
    sck_dly_d   = sck_sync_q;
    mosi_meta_d = spi.SPI_MOSI;
    mosi_sync_d = mosi_meta_q;
    prime_d     = {prime_q[1:0], 1'b1};
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      prime_q     <= 3'b000;
    end else begin
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      cs_dly_q    <= cs_dly_d;
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_dly_q   <= sck_dly_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      prime_q     <= prime_d;
    end
  end

  // Edges are suppressed until the chains hold real pin values; otherwise the
  // reset value of CS_N (high) racing a low pin looks like a fresh frame start.
  assign sync_vld = prime_q[2];
  assign cs_n_s   = cs_sync_q;
  assign mosi_s   = mosi_sync_q;
  assign cs_fall  = sync_vld &  cs_dly_q  & ~cs_sync_q;
  assign cs_rise  = sync_vld & ~cs_dly_q  &  cs_sync_q;
  // MOSI runs through the same depth as SCK, so mosi_s is aligned with this strobe.
  assign sck_rise = sync_vld &  sck_sync_q & ~sck_dly_q;

endmodule

// File: rtl/ptmch_cmd_mon.sv
// Purpose : decode SPI-NAND opcode + row address per CS_N frame, window-compare, count matches, pulse trigger.
// Latency : counters/TRG_PLS update 2 cycles after the cycle that detects the last address SCK rise.
// Backpressure: none; passive monitor. Ports: CLK100M, RESET_N, spi (slave), 4x LOW/HIGH windows,
//   CNT_CLR, PRGEXCT/RDSTAT/BLKERS/PDREAD counters, TRG_PLS, TRG_CMD.
module ptmch_cmd_mon
  import ptmch_pkg::*;
(
  input  logic              CLK100M,
  input  logic              RESET_N,
  ptmch_cmd_mon_if.slave    spi,
  input  logic [ADDR_W-1:0] PRGEXCT_LOW_ADDR,
  input  logic [ADDR_W-1:0] PRGEXCT_HIGH_ADDR,
  input  logic [ADDR_W-1:0] RDSTAT_LOW_ADDR,
  input  logic [ADDR_W-1:0] RDSTAT_HIGH_ADDR,
  input  logic [ADDR_W-1:0] BLKERS_LOW_ADDR,
  input  logic [ADDR_W-1:0] BLKERS_HIGH_ADDR,
  input  logic [ADDR_W-1:0] PDREAD_LOW_ADDR,
  input  logic [ADDR_W-1:0] PDREAD_HIGH_ADDR,
  input  logic              CNT_CLR,
  output logic [CNT_W-1:0]  PRGEXCT,
  output logic [CNT_W-1:0]  RDSTAT,
  output logic [CNT_W-1:0]  BLKERS,
  output logic [CNT_W-1:0]  PDREAD,
  output logic              TRG_PLS,
  output logic [1:0]        TRG_CMD
);

  logic cs_n_s, cs_fall, cs_rise, sck_rise, mosi_s, sync_vld;

  ptmch_spi_sync u_sync (
    .CLK100M  (CLK100M),
    .RESET_N  (RESET_N),
    .spi      (spi),
    .cs_n_s   (cs_n_s),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .sck_rise (sck_rise),
    .mosi_s   (mosi_s),
    .sync_vld (sync_vld)
  );

  state_e             state_q,     state_d;
  logic [4:0]         bit_cnt_q,   bit_cnt_d;
  logic [4:0]         addr_last_q, addr_last_d;
  cmd_e               cmd_q,       cmd_d;
  logic [ADDR_W-1:0]  shift_q,     shift_d;
  logic [CNT_W-1:0]   prgexct_q,   prgexct_d;
  logic [CNT_W-1:0]   rdstat_q,    rdstat_d;
  logic [CNT_W-1:0]   blkers_q,    blkers_d;
  logic [CNT_W-1:0]   pdread_q,    pdread_d;
  logic               trg_pls_q,   trg_pls_d;
  cmd_e               trg_cmd_q,   trg_cmd_d;

  op_dec_t            op_dec;
  logic [ADDR_W-1:0]  win_low, win_high;
  logic               match;

  // Opcode byte completes with the bit arriving this cycle.
  assign op_dec = decode_op({shift_q[6:0], mosi_s});

  always_comb begin
    win_low  = PRGEXCT_LOW_ADDR;
    win_high = PRGEXCT_HIGH_ADDR;
    case (cmd_q)
      CMD_PRGEXCT: begin win_low = PRGEXCT_LOW_ADDR; win_high = PRGEXCT_HIGH_ADDR; end
      CMD_RDSTAT:  begin win_low = RDSTAT_LOW_ADDR;  win_high = RDSTAT_HIGH_ADDR;  end
      CMD_BLKERS:  begin win_low = BLKERS_LOW_ADDR;  win_high = BLKERS_HIGH_ADDR;  end
      CMD_PDREAD:  begin win_low = PDREAD_LOW_ADDR;  win_high = PDREAD_HIGH_ADDR;  end
      default:     begin win_low = PRGEXCT_LOW_ADDR; win_high = PRGEXCT_HIGH_ADDR; end
    endcase
  end

  // LOW > HIGH yields an empty window naturally. The shifter starts cleared,
  // so an 8-bit RDSTAT address is already zero-extended.
  assign match = (shift_q >= win_low) && (shift_q <= win_high);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_last_d = addr_last_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    prgexct_d   = prgexct_q;
    rdstat_d    = rdstat_q;
    blkers_d    = blkers_q;
    pdread_d    = pdread_q;
    trg_pls_d   = 1'b0;
    trg_cmd_d   = trg_cmd_q;

    case (state_q)
      ST_IDLE: begin
        if (sync_vld && !cs_n_s) begin
          bit_cnt_d = 5'd0;
          shift_d   = '0;
          // Low without a fresh fall means we joined mid-frame (e.g. after reset).
          state_d   = cs_fall ? ST_OPCODE : ST_SKIP;
        end
      end
      ST_OPCODE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          shift_d   = {shift_q[ADDR_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            if (op_dec.known) begin
              state_d     = ST_ADDR;
              cmd_d       = op_dec.cmd;
              addr_last_d = op_dec.addr_last;
              bit_cnt_d   = 5'd0;
              shift_d     = '0;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          shift_d   = {shift_q[ADDR_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == addr_last_q) begin
            state_d = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        if (match) begin
          trg_pls_d = 1'b1;
          trg_cmd_d = cmd_q;
          case (cmd_q)
            CMD_PRGEXCT: prgexct_d = sat_inc(prgexct_q);
            CMD_RDSTAT:  rdstat_d  = sat_inc(rdstat_q);
            CMD_BLKERS:  blkers_d  = sat_inc(blkers_q);
            CMD_PDREAD:  pdread_d  = sat_inc(pdread_q);
            default:     prgexct_d = prgexct_q;
          endcase
        end
        state_d = cs_n_s ? ST_IDLE : ST_SKIP;
      end
      ST_SKIP: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides a coincident increment.
    if (CNT_CLR) begin
      prgexct_d = '0;
      rdstat_d  = '0;
      blkers_d  = '0;
      pdread_d  = '0;
    end
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      addr_last_q <= 5'd0;
      cmd_q       <= CMD_PRGEXCT;
      shift_q     <= '0;
      prgexct_q   <= '0;
      rdstat_q    <= '0;
      blkers_q    <= '0;
      pdread_q    <= '0;
      trg_pls_q   <= 1'b0;
      trg_cmd_q   <= CMD_PRGEXCT;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_last_q <= addr_last_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      prgexct_q   <= prgexct_d;
      rdstat_q    <= rdstat_d;
      blkers_q    <= blkers_d;
      pdread_q    <= pdread_d;
      trg_pls_q   <= trg_pls_d;
      trg_cmd_q   <= trg_cmd_d;
    end
  end

  assign PRGEXCT = prgexct_q;
  assign RDSTAT  = rdstat_q;
  assign BLKERS  = blkers_q;
  assign PDREAD  = pdread_q;
  assign TRG_PLS = trg_pls_q;
  assign TRG_CMD = trg_cmd_q;

endmodule

// File: tb/tb_ptmch_cmd_mon.sv
// Purpose : self-checking bench for ptmch_cmd_mon; directed SPI frames, trigger scoreboard.
// Latency : n/a.
// Backpressure: n/a. Expected triggers are queued at stimulus time and popped by a monitor on each TRG_PLS.
module tb_ptmch_cmd_mon;
  import ptmch_pkg::*;

  logic        CLK100M = 1'b0;
  logic        RESET_N;
  logic        CNT_CLR;
  logic [23:0] PRGEXCT_LOW_ADDR, PRGEXCT_HIGH_ADDR;
  logic [23:0] RDSTAT_LOW_ADDR,  RDSTAT_HIGH_ADDR;
  logic [23:0] BLKERS_LOW_ADDR,  BLKERS_HIGH_ADDR;
  logic [23:0] PDREAD_LOW_ADDR,  PDREAD_HIGH_ADDR;
  logic [31:0] PRGEXCT, RDSTAT, BLKERS, PDREAD;
  logic        TRG_PLS;
  logic [1:0]  TRG_CMD;

  ptmch_cmd_mon_if spi_if ();

  ptmch_cmd_mon dut (
    .CLK100M           (CLK100M),
    .RESET_N           (RESET_N),
    .spi               (spi_if),
    .PRGEXCT_LOW_ADDR  (PRGEXCT_LOW_ADDR),
    .PRGEXCT_HIGH_ADDR (PRGEXCT_HIGH_ADDR),
    .RDSTAT_LOW_ADDR   (RDSTAT_LOW_ADDR),
    .RDSTAT_HIGH_ADDR  (RDSTAT_HIGH_ADDR),
    .BLKERS_LOW_ADDR   (BLKERS_LOW_ADDR),
    .BLKERS_HIGH_ADDR  (BLKERS_HIGH_ADDR),
    .PDREAD_LOW_ADDR   (PDREAD_LOW_ADDR),
    .PDREAD_HIGH_ADDR  (PDREAD_HIGH_ADDR),
    .CNT_CLR           (CNT_CLR),
    .PRGEXCT           (PRGEXCT),
    .RDSTAT            (RDSTAT),
    .BLKERS            (BLKERS),
    .PDREAD            (PDREAD),
    .TRG_PLS           (TRG_PLS),
    .TRG_CMD           (TRG_CMD)
  );

  always #5 CLK100M = ~CLK100M;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input logic [1:0] c);
    case (c)
      2'd0:    return PRGEXCT;
      2'd1:    return RDSTAT;
      2'd2:    return BLKERS;
      default: return PDREAD;
    endcase
  endfunction

  // Monitor: every trigger pulse must match the oldest queued expectation.
  always @(negedge CLK100M) begin
    exp_t e;
    if (RESET_N === 1'b1 && TRG_PLS === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_trg: TRG_PLS=1 TRG_CMD=%0d, expected no trigger", TRG_CMD);
      end else begin
        e = exp_q.pop_front();
        chk("trg_cmd", {30'd0, TRG_CMD}, {30'd0, e.cmd});
        chk("trg_cnt", cnt_of(e.cmd), e.cnt);
      end
    end
  end

  // One CS_N-low frame: opcode, then nbits address-phase bits (bits past addr_len are 1s).
  task automatic spi_frame(input logic [7:0] op, input logic [23:0] addr,
                           input int addr_len, input int nbits, input bit clr_last);
    spi_if.SPI_CS_N = 1'b0;
    repeat (4) @(negedge CLK100M);
    for (int i = 0; i < 8 + nbits; i++) begin
      logic b;
      if (i < 8)                 b = op[7-i];
      else if (i - 8 < addr_len) b = addr[addr_len-1-(i-8)];
      else                       b = 1'b1;
      spi_if.SPI_MOSI = b;
      repeat (4) @(negedge CLK100M);
      spi_if.SPI_SCK = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge CLK100M);
        // Lands CNT_CLR on the clock edge that registers the final-bit evaluation.
        if (clr_last && i == 8 + nbits - 1) begin
          if (k == 3) CNT_CLR = 1'b1;
          if (k == 4) CNT_CLR = 1'b0;
        end
      end
      spi_if.SPI_SCK = 1'b0;
    end
    repeat (6) @(negedge CLK100M);
    spi_if.SPI_CS_N = 1'b1;
    repeat (8) @(negedge CLK100M);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge CLK100M);
      t++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N           = 1'b0;
    CNT_CLR           = 1'b0;
    spi_if.SPI_CS_N   = 1'b1;
    spi_if.SPI_SCK    = 1'b0;
    spi_if.SPI_MOSI   = 1'b0;
    PDREAD_LOW_ADDR   = 24'h000080;  PDREAD_HIGH_ADDR  = 24'h000200;
    BLKERS_LOW_ADDR   = 24'h000000;  BLKERS_HIGH_ADDR  = 24'hFFFFFF;
    RDSTAT_LOW_ADDR   = 24'h0000C0;  RDSTAT_HIGH_ADDR  = 24'h0000C0;
    PRGEXCT_LOW_ADDR  = 24'h000010;  PRGEXCT_HIGH_ADDR = 24'h00000F;
    repeat (3) @(negedge CLK100M);

    chk("rst_prgexct", PRGEXCT, 32'd0);
    chk("rst_rdstat",  RDSTAT,  32'd0);
    chk("rst_blkers",  BLKERS,  32'd0);
    chk("rst_pdread",  PDREAD,  32'd0);
    chk("rst_trg_pls", {31'd0, TRG_PLS}, 32'd0);
    chk("rst_trg_cmd", {30'd0, TRG_CMD}, 32'd0);

    // Reset released while CS_N already low: the frame in flight must not count.
    spi_if.SPI_CS_N = 1'b0;
    repeat (5) @(negedge CLK100M);
    RESET_N = 1'b1;
    spi_frame(8'h13, 24'h000100, 24, 24, 1'b0);
    drain("midframe_drain");
    chk("midframe_pdread", PDREAD, 32'd0);

    // Page Data Read inside window, then just above it, then with trailing bytes.
    exp_q.push_back('{cmd: 2'd3, cnt: 32'd1});
    spi_frame(8'h13, 24'h000100, 24, 24, 1'b0);
    drain("pdread_drain");
    chk("pdread_cnt", PDREAD, 32'd1);
    chk("pdread_trg_cmd", {30'd0, TRG_CMD}, 32'd3);
    spi_frame(8'h13, 24'h000201, 24, 24, 1'b0);
    chk("pdread_above", PDREAD, 32'd1);
    exp_q.push_back('{cmd: 2'd3, cnt: 32'd2});
    spi_frame(8'h13, 24'h000180, 24, 32, 1'b0);
    drain("pdread_trail_drain");
    chk("pdread_trail", PDREAD, 32'd2);

    // Block Erase aborted after 12 address bits, then a full frame at address 0.
    spi_frame(8'hD8, 24'h000000, 24, 12, 1'b0);
    chk("blkers_abort", BLKERS, 32'd0);
    exp_q.push_back('{cmd: 2'd2, cnt: 32'd1});
    spi_frame(8'hD8, 24'h000000, 24, 24, 1'b0);
    drain("blkers_drain");
    chk("blkers_cnt", BLKERS, 32'd1);

    // Read Status single-address window with 8-bit address; one miss.
    exp_q.push_back('{cmd: 2'd1, cnt: 32'd1});
    spi_frame(8'h0F, 24'h0000C0, 8, 8, 1'b0);
    drain("rdstat_drain");
    chk("rdstat_cnt", RDSTAT, 32'd1);
    chk("rdstat_trg_cmd", {30'd0, TRG_CMD}, 32'd1);
    spi_frame(8'h0F, 24'h0000C1, 8, 8, 1'b0);
    chk("rdstat_miss", RDSTAT, 32'd1);

    // Inverted Program Execute window never matches.
    spi_frame(8'h10, 24'h000010, 24, 24, 1'b0);
    chk("prgexct_empty_win", PRGEXCT, 32'd0);

    // Saturation from a preloaded counter, then clear coincident with increment.
    PRGEXCT_LOW_ADDR  = 24'h000000;
    PRGEXCT_HIGH_ADDR = 24'hFFFFFF;
    @(negedge CLK100M);
    force dut.prgexct_q = 32'hFFFF_FFFE;
    @(negedge CLK100M);
    release dut.prgexct_q;
    @(negedge CLK100M);
    chk("prgexct_preload", PRGEXCT, 32'hFFFF_FFFE);
    exp_q.push_back('{cmd: 2'd0, cnt: 32'hFFFF_FFFF});
    spi_frame(8'h10, 24'h123456, 24, 24, 1'b0);
    exp_q.push_back('{cmd: 2'd0, cnt: 32'hFFFF_FFFF});
    spi_frame(8'h10, 24'hFFFFFF, 24, 24, 1'b0);
    drain("prgexct_sat_drain");
    chk("prgexct_sat", PRGEXCT, 32'hFFFF_FFFF);
    exp_q.push_back('{cmd: 2'd0, cnt: 32'd0});
    spi_frame(8'h10, 24'h000000, 24, 24, 1'b1);
    drain("clr_drain");
    chk("clr_prgexct", PRGEXCT, 32'd0);
    chk("clr_pdread",  PDREAD,  32'd0);

    // Unknown opcode followed by an address that would hit every window.
    PDREAD_LOW_ADDR  = 24'h000000;
    PDREAD_HIGH_ADDR = 24'hFFFFFF;
    spi_frame(8'h9F, 24'h0000C0, 24, 24, 1'b0);
    repeat (20) @(negedge CLK100M);
    chk("unk_prgexct", PRGEXCT, 32'd0);
    chk("unk_blkers",  BLKERS,  32'd0);
    chk("unk_pdread",  PDREAD,  32'd0);
    chk("unk_trg_pls", {31'd0, TRG_PLS}, 32'd0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ptmch_cmd_mon.md
# ptmch_cmd_mon

SPI-NAND command monitor and trigger sequencer for the pattern-match core. Samples the flash SPI bus in the CLK100M domain, decodes opcode and page/row address of each transaction, and compares the address against the per-command low/high windows held by the register block. Drives the per-command 32-bit match counters read back over Avalon, plus a trigger pulse to the capture logic.

## Interface
- P_OP_PRGEXCT, 8'h10, Program Execute opcode
- P_OP_RDSTAT, 8'h0F, Read Status opcode (8-bit address phase)
- P_OP_BLKERS, 8'hD8, 128 KB Block Erase opcode
- P_OP_PDREAD, 8'h13, Page Data Read opcode
- CLK100M  in  1  system clock, 100 MHz
- RESET_N  in  1  reset, asynchronous, active-low
- SPI_CS_N  in  1  flash chip select, asynchronous to CLK100M
- SPI_SCK  in  1  flash clock, asynchronous, max 25 MHz, mode 0
- SPI_MOSI  in  1  flash data in, asynchronous
- PRGEXCT_LOW_ADDR / PRGEXCT_HIGH_ADDR  in  24 each  Program Execute window, inclusive
- RDSTAT_LOW_ADDR / RDSTAT_HIGH_ADDR  in  24 each  Read Status window
- BLKERS_LOW_ADDR / BLKERS_HIGH_ADDR  in  24 each  Block Erase window
- PDREAD_LOW_ADDR / PDREAD_HIGH_ADDR  in  24 each  Page Data Read window
- CNT_CLR  in  1  synchronous one-cycle pulse, clears all counters
- PRGEXCT, RDSTAT, BLKERS, PDREAD  out  32 each  match counters, reset 0
- TRG_PLS  out  1  one-cycle pulse per match, reset 0
- TRG_CMD  out  2  command of last match (0 PRGEXCT, 1 RDSTAT, 2 BLKERS, 3 PDREAD), reset 0

## Operation
- SCK, CS_N, MOSI each pass two synchronizer flops, plus a third SCK flop for rising-edge detect; MOSI sampled at synchronized SCK rise, MSB first.
- States: IDLE, OPCODE, ADDR, EVAL, SKIP.
- IDLE: synchronized CS_N low -> OPCODE, bit counter 0.
- OPCODE: shift 8 bits; at 8th bit, known opcode -> ADDR with length 24 (8 for RDSTAT); unknown -> SKIP.
- ADDR: shift address bits; at last bit -> EVAL. RDSTAT address zero-extended to 24 bits.
- EVAL (one cycle): match = LOW <= addr <= HIGH, unsigned, windows sampled this cycle; then -> SKIP.
- SKIP: ignore data until synchronized CS_N high -> IDLE.
- Synchronized CS_N high in OPCODE/ADDR: abort, no count, -> IDLE. CS_N high in EVAL: evaluation completes, then IDLE.
- On match: matching counter +1, saturating at 32'hFFFF_FFFF; TRG_PLS=1; TRG_CMD updated.
- LOW > HIGH: window empty, never matches. LOW=0, HIGH=FFFFFF: every transaction of that opcode matches.
- CNT_CLR coincident with increment: clear wins, counter reads 0.
- One evaluation per CS_N-low frame; trailing bytes ignored.

## Timing
- Pin-to-sync latency: 2 CLK100M; edge detect: +1.
- Counter/TRG_PLS registered in the cycle after EVAL, i.e. 2 cycles after the cycle detecting the final address bit's SCK rise.
- CS_N high-to-IDLE: 2 sync cycles + 1; a new frame may start immediately after IDLE.
- SCK high/low each >= 2 CLK100M periods (25 MHz max); faster SCK is unsupported.
- RESET_N asserted mid-frame: all state/outputs cleared immediately; after release, FSM waits in IDLE for the next CS_N falling edge; the partial frame in flight is skipped (CS_N already low -> SKIP until high).

## Structure
- Package ptmch_pkg: opcode constants, state enum, TRG_CMD encoding, counter width constant.
- Sub-module ptmch_spi_sync: synchronizers plus SCK rise and CS_N rise/fall detect; main module holds FSM, shifter, comparators, counters.

## Test plan
- Reset -> all counters 0, TRG_PLS 0, TRG_CMD 0; release with CS_N low mid-frame -> no count.
- Opcode 0x13, addr 0x000100, PDREAD window 0x000080..0x000200 -> PDREAD=1, single TRG_PLS, TRG_CMD=3; addr 0x000201 -> no change.
- Opcode 0xD8 aborted after 12 address bits (CS_N high) -> BLKERS stays 0; next full frame addr 0 with default window -> BLKERS=1.
- Opcode 0x0F, addr 0xC0, RDSTAT window 0xC0..0xC0 -> RDSTAT=1; PRGEXCT window low 0x10, high 0x0F, opcode 0x10 addr 0x10 -> no match.
- PRGEXCT forced to FFFFFFFE, two matching frames -> FFFFFFFF, stays; CNT_CLR in same cycle as increment -> 0.
- Unknown opcode 0x9F followed by 24 bits matching any window -> no count, no trigger.
